// File: rtl/game_pkg.sv
// Shared definitions for the game event reporter: event codes, FSM states,
// register addresses and the power-on defaults of the previous-frame snapshot.
package game_pkg;

  localparam int NUM_EVENTS = 6;

  typedef enum logic [3:0] {
    EV_DOT         = 4'd0,
    EV_LIFE_LOST   = 4'd1,
    EV_GAME_OVER   = 4'd2,
    EV_POWER_ON    = 4'd3,
    EV_POWER_OFF   = 4'd4,
    EV_GHOST_EATEN = 4'd5
  } event_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_EMIT
  } state_t;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_DATA    = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_FRAME   = 2'd3;

  localparam logic [1:0] LIVES_RESET = 2'd2;
  localparam logic [2:0] GHOST_RESET = 3'b111;

  // Lowest-numbered pending event goes first, giving ascending code order.
  function automatic event_code_t lowest_event(input logic [NUM_EVENTS-1:0] mask);
    event_code_t code;
    code = EV_DOT;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (mask[i]) code = event_code_t'(i[3:0]);
    end
    return code;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// 32-bit event queue with push/pop/flush, occupancy count and a sticky overflow flag.
module event_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_h,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  input  logic          flush,
  input  logic          clr_ovf,
  output logic [31:0]   head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A simultaneous pop frees the slot, so a push into a full queue still lands.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h)                      ovf <= 1'b0;
    else if (push && !flush && !do_push) ovf <= 1'b1;
    else if (clr_ovf)                 ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/game_event_reporter.sv
// Turns per-frame game state changes into timestamped event words queued for
// the Nios II over an Avalon-MM slave, with a level interrupt when non-empty.
module game_event_reporter
  import game_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        Clk,
  input  logic        Reset_h,
  input  logic        frame_vs,
  input  logic [10:0] score,
  input  logic [1:0]  lives,
  input  logic        death,
  input  logic        reversal,
  input  logic [2:0]  ghost_en,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic vs_meta, vs_sync, vs_prev, frame_tick;
  logic [15:0] frame_cnt;
  state_t state, state_next;
  logic tick_pend;

  logic [NUM_EVENTS-1:0] pending, capture_mask;
  logic [10:0] prev_score, snap_score;
  logic [1:0]  prev_lives, snap_lives;
  logic        prev_death, prev_rev;
  logic [2:0]  prev_ghost, snap_ghost;
  logic [7:0]  snap_frame;

  logic        ev_push;
  event_code_t ev_code;
  logic [19:0] ev_payload;
  logic [31:0] ev_word;

  logic          rd_sel, wr_sel, ctrl_wr, fifo_pop, fifo_flush, clr_ovf, irq_en;
  logic [31:0]   fifo_head;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty, fifo_ovf;
  logic          unused_wdata;

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= frame_vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end
  assign frame_tick = vs_sync && !vs_prev;

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h)         frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= frame_cnt + 16'd1;
  end

  // A tick arriving while busy is remembered once; in IDLE a new tick that
  // coincides with a remembered one stays remembered.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h)                tick_pend <= 1'b0;
    else if (state == ST_IDLE)  tick_pend <= tick_pend && frame_tick;
    else if (frame_tick)        tick_pend <= 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (frame_tick || tick_pend) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_EMIT;
      ST_EMIT:    if (pending == '0) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ev_push    = (state == ST_EMIT) && (pending != '0);
    ev_code    = lowest_event(pending);
    ev_payload = '0;
    case (ev_code)
      EV_DOT:         ev_payload = {9'd0, snap_score};
      EV_LIFE_LOST:   ev_payload = {18'd0, snap_lives};
      EV_GHOST_EATEN: ev_payload = {17'd0, snap_ghost};
      default:        ev_payload = '0;
    endcase
  end
  assign ev_word = {snap_frame, ev_code, ev_payload};

  assign capture_mask = {
    |(prev_ghost & ~ghost_en),
    prev_rev && !reversal,
    !prev_rev && reversal,
    !prev_death && death,
    lives < prev_lives,
    score != prev_score
  };

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      prev_score <= '0;
      prev_lives <= LIVES_RESET;
      prev_death <= 1'b0;
      prev_rev   <= 1'b0;
      prev_ghost <= GHOST_RESET;
      pending    <= '0;
      snap_score <= '0;
      snap_lives <= '0;
      snap_ghost <= '0;
      snap_frame <= '0;
    end else if (state == ST_CAPTURE) begin
      prev_score <= score;
      prev_lives <= lives;
      prev_death <= death;
      prev_rev   <= reversal;
      prev_ghost <= ghost_en;
      pending    <= capture_mask;
      snap_score <= score;
      snap_lives <= lives;
      snap_ghost <= prev_ghost & ~ghost_en;
      snap_frame <= frame_cnt[7:0];
    end else if (ev_push) begin
      pending <= pending & (pending - NUM_EVENTS'(1));
    end
  end

  assign rd_sel     = avs_chipselect && avs_read;
  assign wr_sel     = avs_chipselect && avs_write;
  assign ctrl_wr    = wr_sel && (avs_address == ADDR_CONTROL);
  assign fifo_pop   = rd_sel && (avs_address == ADDR_DATA);
  assign fifo_flush = ctrl_wr && avs_writedata[1];
  assign clr_ovf    = ctrl_wr && avs_writedata[2];
  assign unused_wdata = ^avs_writedata[31:3];

  event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (Clk),
    .reset_h  (Reset_h),
    .push     (ev_push),
    .push_data(ev_word),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .clr_ovf  (clr_ovf),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ovf      (fifo_ovf)
  );

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      irq_en       <= 1'b0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (ctrl_wr) irq_en <= avs_writedata[0];
      irq <= irq_en && !fifo_empty;
      if (rd_sel) begin
        case (avs_address)
          ADDR_STATUS:  avs_readdata <= {8'(fifo_count), 21'd0, fifo_ovf, fifo_full, fifo_empty};
          ADDR_DATA:    avs_readdata <= fifo_empty ? 32'd0 : fifo_head;
          ADDR_CONTROL: avs_readdata <= {31'd0, irq_en};
          ADDR_FRAME:   avs_readdata <= {16'd0, frame_cnt};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_event_reporter.sv
// Directed bench for game_event_reporter: a table of frames with expected
// event words, plus hand-timed sequences for the multi-cycle corner cases.
module tb_game_event_reporter;
  import game_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_h;
  logic        frame_vs;
  logic [10:0] score;
  logic [1:0]  lives;
  logic        death;
  logic        reversal;
  logic [2:0]  ghost_en;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;
  int frame_no = 0;
  logic [31:0] rd;

  game_event_reporter #(.FIFO_DEPTH(16)) dut (
    .Clk(Clk), .Reset_h(Reset_h), .frame_vs(frame_vs),
    .score(score), .lives(lives), .death(death), .reversal(reversal), .ghost_en(ghost_en),
    .avs_address(avs_address), .avs_chipselect(avs_chipselect), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [10:0] score;
    logic [1:0]  lives;
    logic        death;
    logic        rev;
    logic [2:0]  ghost;
    int          n;
    logic [3:0]  code [3];
    logic [19:0] pay  [3];
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mkv(input logic [10:0] s, input logic [1:0] l, input logic d,
                               input logic r, input logic [2:0] g, input int n,
                               input logic [3:0] c0, input logic [19:0] p0,
                               input logic [3:0] c1, input logic [19:0] p1,
                               input logic [3:0] c2, input logic [19:0] p2);
    vec_t v;
    v.score = s; v.lives = l; v.death = d; v.rev = r; v.ghost = g; v.n = n;
    v.code[0] = c0; v.pay[0] = p0;
    v.code[1] = c1; v.pay[1] = p1;
    v.code[2] = c2; v.pay[2] = p2;
    return v;
  endfunction

  function automatic logic [31:0] mk_word(input int fr, input logic [3:0] code, input logic [19:0] pay);
    return {fr[7:0], code, pay};
  endfunction

  function automatic logic [31:0] status_word(input int cnt, input logic ovf, input logic full);
    return {8'(cnt), 21'd0, ovf, full, cnt == 0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge Clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge Clk);
    avs_chipselect = 1'b0; avs_write = 1'b0; avs_writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge Clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    @(negedge Clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic set_game(input logic [10:0] s, input logic [1:0] l, input logic d,
                          input logic r, input logic [2:0] g);
    score = s; lives = l; death = d; reversal = r; ghost_en = g;
  endtask

  task automatic frame(input logic [10:0] s, input logic [1:0] l, input logic d,
                       input logic r, input logic [2:0] g);
    @(negedge Clk);
    set_game(s, l, d, r, g);
    frame_vs = 1'b1;
    wait_cyc(3);
    frame_vs = 1'b0;
    wait_cyc(10);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_h = 1'b1; frame_vs = 1'b0;
    set_game(11'd0, 2'd2, 1'b0, 1'b0, 3'b111);
    wait_cyc(2);
    Reset_h = 1'b0;
    wait_cyc(2);
  endtask

  initial begin
    Reset_h = 1'b1; frame_vs = 1'b0;
    avs_address = '0; avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    set_game(11'd0, 2'd2, 1'b0, 1'b0, 3'b111);

    vecs[0] = mkv(11'd5, 2'd2, 1'b0, 1'b0, 3'b111, 1, EV_DOT, 20'd5, 4'd0, 20'd0, 4'd0, 20'd0);
    vecs[1] = mkv(11'd6, 2'd1, 1'b0, 1'b0, 3'b110, 3, EV_DOT, 20'd6, EV_LIFE_LOST, 20'd1, EV_GHOST_EATEN, 20'h1);
    vecs[2] = mkv(11'd6, 2'd1, 1'b0, 1'b1, 3'b110, 1, EV_POWER_ON, 20'd0, 4'd0, 20'd0, 4'd0, 20'd0);
    vecs[3] = mkv(11'd6, 2'd1, 1'b0, 1'b0, 3'b010, 2, EV_POWER_OFF, 20'd0, EV_GHOST_EATEN, 20'h4, 4'd0, 20'd0);
    vecs[4] = mkv(11'd6, 2'd0, 1'b1, 1'b0, 3'b010, 2, EV_LIFE_LOST, 20'd0, EV_GAME_OVER, 20'd0, 4'd0, 20'd0);
    vecs[5] = mkv(11'd6, 2'd0, 1'b1, 1'b0, 3'b010, 0, 4'd0, 20'd0, 4'd0, 20'd0, 4'd0, 20'd0);
    vecs[6] = mkv(11'd7, 2'd3, 1'b1, 1'b0, 3'b111, 1, EV_DOT, 20'd7, 4'd0, 20'd0, 4'd0, 20'd0);
    vecs[7] = mkv(11'd7, 2'd3, 1'b0, 1'b0, 3'b111, 0, 4'd0, 20'd0, 4'd0, 20'd0, 4'd0, 20'd0);
    vecs[8] = mkv(11'd7, 2'd2, 1'b0, 1'b1, 3'b000, 3, EV_LIFE_LOST, 20'd2, EV_POWER_ON, 20'd0, EV_GHOST_EATEN, 20'h7);

    wait_cyc(3);
    Reset_h = 1'b0;
    wait_cyc(2);

    // Reset state
    check("reset_readdata", avs_readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    bus_read(ADDR_STATUS, rd);  check("reset_status", rd, 32'h0000_0001);
    bus_read(ADDR_FRAME, rd);   check("reset_frame", rd, 32'd0);

    // First frame: score 0->1, irq only once enabled
    frame_no++;
    frame(11'd1, 2'd2, 1'b0, 1'b0, 3'b111);
    bus_read(ADDR_STATUS, rd);  check("f1_status", rd, status_word(1, 1'b0, 1'b0));
    check("f1_irq_disabled", {31'd0, irq}, 32'd0);
    bus_write(ADDR_CONTROL, 32'h1);
    wait_cyc(1);
    check("f1_irq_enabled", {31'd0, irq}, 32'd1);
    bus_read(ADDR_CONTROL, rd); check("f1_control", rd, 32'd1);
    bus_read(ADDR_DATA, rd);    check("f1_dot", rd, mk_word(1, EV_DOT, 20'd1));
    wait_cyc(1);
    check("f1_irq_drained", {31'd0, irq}, 32'd0);

    // Table of frames
    foreach (vecs[i]) begin
      frame_no++;
      frame(vecs[i].score, vecs[i].lives, vecs[i].death, vecs[i].rev, vecs[i].ghost);
      bus_read(ADDR_STATUS, rd);
      check($sformatf("vec%0d_status", i), rd, status_word(vecs[i].n, 1'b0, 1'b0));
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].n != 0});
      for (int k = 0; k < vecs[i].n; k++) begin
        bus_read(ADDR_DATA, rd);
        check($sformatf("vec%0d_word%0d", i, k), rd, mk_word(frame_no, vecs[i].code[k], vecs[i].pay[k]));
      end
    end

    // Second tick arrives during EMIT: held and processed afterwards
    @(negedge Clk); score = 11'd8; frame_vs = 1'b1;
    @(negedge Clk); frame_vs = 1'b0;
    @(negedge Clk); frame_vs = 1'b1;
    @(negedge Clk);
    @(negedge Clk); score = 11'd9;
    wait_cyc(3); frame_vs = 1'b0;
    wait_cyc(10);
    bus_read(ADDR_STATUS, rd); check("latch_status", rd, status_word(2, 1'b0, 1'b0));
    bus_read(ADDR_DATA, rd);   check("latch_word0", rd, mk_word(frame_no + 1, EV_DOT, 20'd8));
    bus_read(ADDR_DATA, rd);   check("latch_word1", rd, mk_word(frame_no + 2, EV_DOT, 20'd9));
    frame_no += 2;
    bus_read(ADDR_FRAME, rd);  check("latch_frame_cnt", rd, 32'(frame_no));

    // Flush written in the same cycle the event is pushed
    @(negedge Clk); score = 11'd10; frame_vs = 1'b1;
    wait_cyc(3);
    bus_write(ADDR_CONTROL, 32'h2);
    frame_vs = 1'b0;
    wait_cyc(10);
    bus_read(ADDR_STATUS, rd); check("flush_push_status", rd, 32'h0000_0001);

    // DATA read on empty queue
    bus_read(ADDR_DATA, rd);   check("empty_read_data", rd, 32'd0);
    bus_read(ADDR_STATUS, rd); check("empty_read_status", rd, 32'h0000_0001);

    // Overflow: 17 DOT frames into a 16-deep queue
    do_reset();
    for (int i = 1; i <= 17; i++) frame(11'(i), 2'd2, 1'b0, 1'b0, 3'b111);
    bus_read(ADDR_STATUS, rd);  check("ovf_status", rd, status_word(16, 1'b1, 1'b1));
    bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
    bus_read(ADDR_STATUS, rd);  check("ro_write_ignored", rd, status_word(16, 1'b1, 1'b1));
    bus_write(ADDR_CONTROL, 32'h4);
    bus_read(ADDR_STATUS, rd);  check("ovf_cleared", rd, status_word(16, 1'b0, 1'b1));
    for (int i = 1; i <= 16; i++) begin
      bus_read(ADDR_DATA, rd);
      check($sformatf("ovf_word%0d", i), rd, mk_word(i, EV_DOT, 20'(i)));
    end
    bus_read(ADDR_STATUS, rd);  check("ovf_drained", rd, 32'h0000_0001);
    bus_read(ADDR_FRAME, rd);   check("ovf_frame_cnt", rd, 32'd17);

    // Reset pulsed while a 3-event burst is being pushed
    do_reset();
    @(negedge Clk); set_game(11'd3, 2'd1, 1'b0, 1'b0, 3'b011); frame_vs = 1'b1;
    wait_cyc(5);
    Reset_h = 1'b1; frame_vs = 1'b0;
    wait_cyc(1);
    Reset_h = 1'b0;
    wait_cyc(10);
    bus_read(ADDR_STATUS, rd); check("reset_mid_emit_status", rd, 32'h0000_0001);
    check("reset_mid_emit_irq", {31'd0, irq}, 32'd0);

    // Frame counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      @(negedge Clk); frame_vs = 1'b1;
      @(negedge Clk); frame_vs = 1'b0;
    end
    wait_cyc(6);
    bus_read(ADDR_FRAME, rd); check("frame_cnt_ffff", rd, 32'h0000_FFFF);
    frame(11'd0, 2'd2, 1'b0, 1'b0, 3'b111);
    bus_read(ADDR_FRAME, rd); check("frame_cnt_wrap", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
